// File: rtl/contra_pkg.sv
// Shared player-life definitions: state encodings and default frame timings.
package contra_pkg;

   typedef logic [1:0] life_state_t;

   localparam life_state_t ALIVE   = 2'd0;
   localparam life_state_t DYING   = 2'd1;
   localparam life_state_t RESPAWN = 2'd2;
   localparam life_state_t OUT     = 2'd3;

   localparam int unsigned MAX_DEATHS_D    = 3;
   localparam int unsigned DEATH_FRAMES_D  = 60;
   localparam int unsigned INVULN_FRAMES_D = 120;

endpackage

// File: rtl/player_life_tracker_frame_countdown.sv
// 8-bit loadable frame down-counter; holds at zero, pauses when en is low.
module frame_countdown (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic [7:0] count,
   output logic       zero
);

   assign zero = (count == '0);

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && !zero)
         count <= count - 8'd1;
   end

endmodule

// File: rtl/player_life_tracker.sv
// Turns per-frame hazard hits into a saturating death count and sequences
// death animation, respawn pulse and post-respawn invulnerability.
module player_life_tracker
   import contra_pkg::*;
#(
   parameter int unsigned MAX_DEATHS    = MAX_DEATHS_D,
   parameter int unsigned DEATH_FRAMES  = DEATH_FRAMES_D,
   parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_D
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       active,
   input  logic       hit_enemy,
   input  logic       hit_bullet,
   input  logic       fell,
   output logic [2:0] lives,
   output logic       dead,
   output logic       invuln,
   output logic       blink,
   output logic       respawn
);

   localparam logic [2:0] LIVES_MAX   = 3'(MAX_DEATHS);
   localparam logic [7:0] DEATH_LOAD  = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES - 1);

   life_state_t state, next_state;
   logic        load, lives_inc, respawn_set, zero;
   logic [7:0]  load_val, timer;
   logic        hazard;
   logic        unused_timer;

   assign hazard = hit_enemy | hit_bullet | fell;

   frame_countdown u_countdown (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (load),
      .load_val  (load_val),
      .en        (active),
      .count     (timer),
      .zero      (zero)
   );

   // Nothing advances while frozen, so every transition is qualified by active.
   always_comb begin
      next_state  = state;
      load        = 1'b0;
      load_val    = '0;
      lives_inc   = 1'b0;
      respawn_set = 1'b0;
      if (active) begin
         case (state)
            ALIVE: begin
               if (hazard) begin
                  next_state = DYING;
                  load       = 1'b1;
                  load_val   = DEATH_LOAD;
                  lives_inc  = 1'b1;
               end
            end
            DYING: begin
               if (zero) begin
                  load = 1'b1;
                  if (lives == LIVES_MAX) begin
                     next_state = OUT;
                     load_val   = '0;
                  end else begin
                     next_state  = RESPAWN;
                     load_val    = INVULN_LOAD;
                     respawn_set = 1'b1;
                  end
               end
            end
            RESPAWN: begin
               // A pit kills through invulnerability and outranks expiry.
               if (fell) begin
                  next_state = DYING;
                  load       = 1'b1;
                  load_val   = DEATH_LOAD;
                  lives_inc  = 1'b1;
               end else if (zero) begin
                  next_state = ALIVE;
               end
            end
            default: next_state = state;
         endcase
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state   <= ALIVE;
         lives   <= '0;
         respawn <= 1'b0;
      end else begin
         state   <= next_state;
         respawn <= respawn_set;
         if (lives_inc && lives < LIVES_MAX)
            lives <= lives + 3'd1;
      end
   end

   assign dead         = (state == DYING) || (state == OUT);
   assign invuln       = (state == RESPAWN);
   assign blink        = invuln & timer[2];
   assign unused_timer = ^{timer[7:3], timer[1:0]};

endmodule

// File: tb/tb_player_life_tracker.sv
// Directed bench for player_life_tracker with default frame timings.
module tb_player_life_tracker;

   logic       frame_clk;
   logic       Reset;
   logic       active;
   logic       hit_enemy;
   logic       hit_bullet;
   logic       fell;
   logic [2:0] lives;
   logic       dead;
   logic       invuln;
   logic       blink;
   logic       respawn;

   int checks = 0;
   int errors = 0;

   player_life_tracker #(
      .MAX_DEATHS    (3),
      .DEATH_FRAMES  (60),
      .INVULN_FRAMES (120)
   ) dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .active     (active),
      .hit_enemy  (hit_enemy),
      .hit_bullet (hit_bullet),
      .fell       (fell),
      .lives      (lives),
      .dead       (dead),
      .invuln     (invuln),
      .blink      (blink),
      .respawn    (respawn)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic step();
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      Reset      = 1'b1;
      active     = 1'b1;
      hit_enemy  = 1'b0;
      hit_bullet = 1'b0;
      fell       = 1'b0;
      step();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; active = 1'b1;
      hit_enemy = 1'b0; hit_bullet = 1'b0; fell = 1'b0;
      #1;
      checks++;
      if ({lives, dead, invuln, blink, respawn} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", {lives, dead, invuln, blink, respawn}, 7'b0);
      end
      step();
      Reset = 1'b0;
   endtask

   task automatic test_death_respawn();
      int resp_cnt, resp_idx, dead_cnt, inv_cnt, inv_first, inv_last, blink_cnt;
      do_reset();
      hit_bullet = 1'b1;
      step();
      hit_bullet = 1'b0;
      checks++;
      if (lives !== 3'd1 || dead !== 1'b1 || invuln !== 1'b0) begin
         errors++;
         $display("FAIL first_death lives=%0d dead=%b invuln=%b exp lives=1 dead=1 invuln=0", lives, dead, invuln);
      end
      resp_cnt = 0; resp_idx = -1; dead_cnt = 1; inv_cnt = 0;
      inv_first = -1; inv_last = -1; blink_cnt = 0;
      for (int k = 1; k <= 185; k++) begin
         step();
         if (respawn === 1'b1) begin
            resp_cnt++;
            if (resp_idx < 0) resp_idx = k;
         end
         if (dead === 1'b1) dead_cnt++;
         if (invuln === 1'b1) begin
            inv_cnt++;
            if (inv_first < 0) inv_first = k;
            inv_last = k;
         end
         if (blink === 1'b1) blink_cnt++;
      end
      checks++;
      if (resp_cnt != 1 || resp_idx != 60) begin
         errors++;
         $display("FAIL respawn_pulse count=%0d frame=%0d exp count=1 frame=60", resp_cnt, resp_idx);
      end
      checks++;
      if (dead_cnt != 60) begin
         errors++;
         $display("FAIL dead_frames got=%0d exp=60", dead_cnt);
      end
      checks++;
      if (inv_cnt != 120 || inv_first != 60 || inv_last != 179) begin
         errors++;
         $display("FAIL invuln_window count=%0d first=%0d last=%0d exp 120/60/179", inv_cnt, inv_first, inv_last);
      end
      checks++;
      if (blink_cnt != 60) begin
         errors++;
         $display("FAIL blink_frames got=%0d exp=60", blink_cnt);
      end
      checks++;
      if (lives !== 3'd1 || dead !== 1'b0 || invuln !== 1'b0) begin
         errors++;
         $display("FAIL back_alive lives=%0d dead=%b invuln=%b exp 1/0/0", lives, dead, invuln);
      end
   endtask

   task automatic test_respawn_immunity();
      int bad;
      do_reset();
      hit_enemy = 1'b1;
      step();
      hit_enemy = 1'b0;
      steps(60);
      checks++;
      if (invuln !== 1'b1) begin
         errors++;
         $display("FAIL enter_respawn invuln=%b exp=1", invuln);
      end
      bad = 0;
      hit_enemy = 1'b1; hit_bullet = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step();
         if (lives !== 3'd1 || dead !== 1'b0) bad++;
      end
      hit_enemy = 1'b0; hit_bullet = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL respawn_immune bad_frames=%0d exp=0 lives=%0d", bad, lives);
      end
      fell = 1'b1;
      step();
      fell = 1'b0;
      checks++;
      if (lives !== 3'd2 || dead !== 1'b1 || invuln !== 1'b0) begin
         errors++;
         $display("FAIL pit_in_respawn lives=%0d dead=%b invuln=%b exp 2/1/0", lives, dead, invuln);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      hit_enemy = 1'b1; hit_bullet = 1'b1; fell = 1'b1;
      step();
      checks++;
      if (lives !== 3'd1) begin
         errors++;
         $display("FAIL simultaneous lives=%0d exp=1", lives);
      end
      steps(3);
      hit_enemy = 1'b0; hit_bullet = 1'b0; fell = 1'b0;
      checks++;
      if (lives !== 3'd1 || dead !== 1'b1) begin
         errors++;
         $display("FAIL dying_ignores lives=%0d dead=%b exp 1/1", lives, dead);
      end
   endtask

   task automatic test_three_deaths();
      int resp_cnt;
      do_reset();
      hit_bullet = 1'b1; step(); hit_bullet = 1'b0;
      steps(60);
      fell = 1'b1; step(); fell = 1'b0;
      steps(60);
      fell = 1'b1; step(); fell = 1'b0;
      checks++;
      if (lives !== 3'd3 || dead !== 1'b1) begin
         errors++;
         $display("FAIL third_death lives=%0d dead=%b exp 3/1", lives, dead);
      end
      resp_cnt = 0;
      for (int k = 0; k < 70; k++) begin
         step();
         if (respawn === 1'b1) resp_cnt++;
      end
      checks++;
      if (resp_cnt != 0 || dead !== 1'b1 || invuln !== 1'b0 || lives !== 3'd3) begin
         errors++;
         $display("FAIL out_state resp=%0d dead=%b invuln=%b lives=%0d exp 0/1/0/3", resp_cnt, dead, invuln, lives);
      end
      hit_enemy = 1'b1; hit_bullet = 1'b1; fell = 1'b1;
      steps(10);
      hit_enemy = 1'b0; hit_bullet = 1'b0; fell = 1'b0;
      checks++;
      if (lives !== 3'd3 || dead !== 1'b1 || respawn !== 1'b0) begin
         errors++;
         $display("FAIL out_saturate lives=%0d dead=%b respawn=%b exp 3/1/0", lives, dead, respawn);
      end
   endtask

   task automatic test_freeze();
      int bad, resp_cnt, resp_idx;
      do_reset();
      hit_enemy = 1'b1; step(); hit_enemy = 1'b0;
      steps(20);
      active = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         hit_bullet = k[0];
         fell = k[1];
         step();
         if (dead !== 1'b1 || respawn !== 1'b0 || lives !== 3'd1 || invuln !== 1'b0) bad++;
      end
      hit_bullet = 1'b0; fell = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL freeze_hold bad_frames=%0d exp=0", bad);
      end
      active = 1'b1;
      resp_cnt = 0; resp_idx = -1;
      for (int j = 1; j <= 45; j++) begin
         step();
         if (respawn === 1'b1) begin
            resp_cnt++;
            if (resp_idx < 0) resp_idx = j;
         end
      end
      checks++;
      if (resp_cnt != 1 || resp_idx != 40) begin
         errors++;
         $display("FAIL freeze_resume count=%0d frame=%0d exp count=1 frame=40", resp_cnt, resp_idx);
      end
   endtask

   task automatic test_reset_mid();
      int resp_cnt;
      do_reset();
      hit_bullet = 1'b1; step(); hit_bullet = 1'b0;
      steps(65);
      Reset = 1'b1;
      #1;
      checks++;
      if ({lives, dead, invuln, blink, respawn} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset_respawn got=%b exp=%b", {lives, dead, invuln, blink, respawn}, 7'b0);
      end
      step();
      Reset = 1'b0;
      hit_enemy = 1'b1; step(); hit_enemy = 1'b0;
      checks++;
      if (lives !== 3'd1 || dead !== 1'b1) begin
         errors++;
         $display("FAIL alive_after_reset lives=%0d dead=%b exp 1/1", lives, dead);
      end
      steps(58);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      resp_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (respawn === 1'b1) resp_cnt++;
      end
      checks++;
      if (resp_cnt != 0 || lives !== 3'd0 || dead !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_dying resp=%0d lives=%0d dead=%b exp 0/0/0", resp_cnt, lives, dead);
      end
   endtask

   initial begin
      test_reset();
      test_death_respawn();
      test_respawn_immunity();
      test_simultaneous();
      test_three_deaths();
      test_freeze();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
